// File: rtl/bsg_tag_tx_pkg.sv
// Shared types and helpers for the bsg_tag serial transmitter.
// header_s documents the frame header layout; its LSB (node_id[0]) leaves the wire first.
package bsg_tag_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        HDR,
        PAY,
        GAP,
        RST_ONES,
        RST_ZEROS
    } state_e;

    localparam int tag_lg_els_gp   = 6;
    localparam int tag_lg_width_gp = 9;

    typedef struct packed {
        logic [tag_lg_width_gp-1:0] len;
        logic                       data_not_reset;
        logic [tag_lg_els_gp-1:0]   node_id;
    } header_s;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bsg_tag_tx_piso.sv
// Loadable right-shift register with a free-running down-counter that stops at zero.
// bit_o is the next bit to transmit; zero_o marks the last cycle of the current phase.
module bsg_tag_tx_piso #(
    parameter int width_p     = 80,
    parameter int cnt_width_p = 11
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   load_i,
    input  logic [width_p-1:0]     data_i,
    input  logic                   shift_i,
    input  logic                   cnt_load_i,
    input  logic [cnt_width_p-1:0] cnt_i,
    output logic                   bit_o,
    output logic                   zero_o
);

    logic [width_p-1:0]     sr;
    logic [cnt_width_p-1:0] cnt;

    // NOTE: sr has no reset: it is always loaded on accept before any bit is read,
    // and the top qualifies every use of bit_o by state.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            sr <= data_i;
        end else if (shift_i) begin
            sr <= {1'b0, sr[width_p-1:1]};
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every flop
    // samples the values from before the edge, independent of block ordering.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (cnt_load_i) begin
            cnt <= cnt_i;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign bit_o  = sr[0];
    assign zero_o = (cnt == '0);

endmodule

// File: rtl/bsg_tag_serial_tx.sv
// bsg_tag serial transmitter: frames parallel tag packets (start, header, payload)
// and master-reset preambles onto registered tag_data_o/tag_en_o.
module bsg_tag_serial_tx
    import bsg_tag_tx_pkg::*;
#(
    parameter int els_p               = 64,
    parameter int lg_width_p          = 9,
    parameter int max_payload_width_p = 64,
    parameter int reset_ones_p        = 1024,
    parameter int reset_zeros_p       = 16,
    parameter int gap_p               = 1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    output logic                           ready_o,
    input  logic [$clog2(els_p)-1:0]       node_id_i,
    input  logic                           data_not_reset_i,
    input  logic [lg_width_p-1:0]          len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    input  logic                           master_reset_v_i,
    output logic                           tag_data_o,
    output logic                           tag_en_o,
    output logic                           busy_o
);

    localparam int lg_els = $clog2(els_p);
    localparam int hdr_w  = lg_els + 1 + lg_width_p;
    localparam int sr_w   = hdr_w + max_payload_width_p;
    localparam int cnt_w  = $clog2(max3(reset_ones_p, max_payload_width_p + 1, hdr_w) + 1);
    localparam logic [lg_width_p:0] max_len = (lg_width_p + 1)'(max_payload_width_p);

    state_e                state, state_n;
    logic [lg_width_p-1:0] len_r;
    logic [cnt_w-1:0]      len_cnt;
    logic [cnt_w-1:0]      cnt_in;
    logic                  load, shift, cnt_load;
    logic                  sbit, zero;
    logic                  accept, gap_done;
    logic                  data_n, en_n;
    logic                  data_r, en_r;

    // Opening ready in the last GAP cycle lets frames run back to back with exactly gap_p zeros.
    assign gap_done = (state == GAP) && zero;
    assign ready_o  = ((state == IDLE) || gap_done) && !master_reset_v_i && !reset_i;
    assign accept   = v_i && ready_o;
    assign busy_o   = (state != IDLE);
    assign len_cnt  = cnt_w'(len_r) - cnt_w'(1);

    bsg_tag_tx_piso #(
        .width_p    (sr_w),
        .cnt_width_p(cnt_w)
    ) piso (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .load_i    (load),
        .data_i    ({payload_i, len_i, data_not_reset_i, node_id_i}),
        .shift_i   (shift),
        .cnt_load_i(cnt_load),
        .cnt_i     (cnt_in),
        .bit_o     (sbit),
        .zero_o    (zero)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            len_r <= len_i;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n  = state;
        load     = 1'b0;
        shift    = 1'b0;
        cnt_load = 1'b0;
        cnt_in   = '0;
        data_n   = 1'b0;
        en_n     = 1'b0;
        case (state)
            IDLE: begin
                if (master_reset_v_i) begin
                    state_n  = RST_ONES;
                    cnt_load = 1'b1;
                    cnt_in   = cnt_w'(reset_ones_p - 1);
                end else if (accept) begin
                    state_n = START;
                    load    = 1'b1;
                end
            end
            START: begin
                en_n     = 1'b1;
                data_n   = 1'b1;
                state_n  = HDR;
                cnt_load = 1'b1;
                cnt_in   = cnt_w'(hdr_w - 1);
            end
            HDR: begin
                en_n   = 1'b1;
                data_n = sbit;
                shift  = 1'b1;
                if (zero) begin
                    cnt_load = 1'b1;
                    if (len_r != '0) begin
                        state_n = PAY;
                        cnt_in  = len_cnt;
                    end else begin
                        state_n = GAP;
                        cnt_in  = cnt_w'(gap_p - 1);
                    end
                end
            end
            PAY: begin
                en_n   = 1'b1;
                data_n = sbit;
                shift  = 1'b1;
                if (zero) begin
                    state_n  = GAP;
                    cnt_load = 1'b1;
                    cnt_in   = cnt_w'(gap_p - 1);
                end
            end
            GAP: begin
                if (zero) begin
                    state_n = accept ? START : IDLE;
                    load    = accept;
                end
            end
            RST_ONES: begin
                en_n   = 1'b1;
                data_n = 1'b1;
                if (zero) begin
                    state_n  = RST_ZEROS;
                    cnt_load = 1'b1;
                    cnt_in   = cnt_w'(reset_zeros_p - 1);
                end
            end
            RST_ZEROS: begin
                en_n = 1'b1;
                if (zero) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_r <= 1'b0;
            en_r   <= 1'b0;
        end else begin
            data_r <= data_n;
            en_r   <= en_n;
        end
    end

    assign tag_data_o = data_r;
    assign tag_en_o   = en_r;

    // Oversized lengths still frame correctly (upper payload bits shift in as 0) but flag misuse.
    always_ff @(posedge clk_i) begin
        if (!reset_i && accept) begin
            assert ({1'b0, len_i} <= max_len)
            else $warning("bsg_tag_serial_tx: len_i=%0d exceeds max_payload_width_p=%0d",
                          len_i, max_payload_width_p);
        end
    end

endmodule

// File: tb/tb_bsg_tag_serial_tx.sv
// Scoreboard bench for bsg_tag_serial_tx: the driver queues expected serial bits at
// accept time, and a negedge monitor pops and compares every enabled bit on the wire.
module tb_bsg_tag_serial_tx;
    import bsg_tag_tx_pkg::*;

    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic        ready_o;
    logic [5:0]  node_id_i;
    logic        data_not_reset_i;
    logic [8:0]  len_i;
    logic [63:0] payload_i;
    logic        master_reset_v_i;
    logic        tag_data_o;
    logic        tag_en_o;
    logic        busy_o;

    int vectors     = 0;
    int miscompares = 0;
    bit exp_q[$];
    bit exp_bit;
    int dummy;

    bsg_tag_serial_tx #(
        .els_p              (64),
        .lg_width_p         (9),
        .max_payload_width_p(64),
        .reset_ones_p       (1024),
        .reset_zeros_p      (16),
        .gap_p              (1)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .v_i             (v_i),
        .ready_o         (ready_o),
        .node_id_i       (node_id_i),
        .data_not_reset_i(data_not_reset_i),
        .len_i           (len_i),
        .payload_i       (payload_i),
        .master_reset_v_i(master_reset_v_i),
        .tag_data_o      (tag_data_o),
        .tag_en_o        (tag_en_o),
        .busy_o          (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [5:0] nid, input logic dnr,
                              input logic [8:0] len, input logic [63:0] pl);
        header_s h;
        h = '{len: len, data_not_reset: dnr, node_id: nid};
        exp_q.push_back(1'b1);
        for (int i = 0; i < $bits(header_s); i++) exp_q.push_back(h[i]);
        for (int i = 0; i < int'(len); i++) begin
            if (i < 64) exp_q.push_back(pl[i]);
            else        exp_q.push_back(1'b0);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the cycle showing the start bit.
    task automatic send(input logic [5:0] nid, input logic dnr, input logic [8:0] len,
                        input logic [63:0] pl, input bit push_model, input bit b2b,
                        output int waited);
        bit got, rdy, pre_en;
        got = 0; rdy = 0; pre_en = 0; waited = 0;
        node_id_i = nid; data_not_reset_i = dnr; len_i = len; payload_i = pl;
        v_i = 1'b1;
        for (int c = 0; c < 2000 && !got; c++) begin
            @(negedge clk);
            rdy    = ready_o;
            pre_en = tag_en_o;
            @(posedge clk);
            if (rdy) got = 1;
            else     waited++;
        end
        #1;
        v_i = 1'b0;
        if (!got) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: no accept after %0d cycles, expected one", waited);
        end else begin
            if (push_model) push_frame(nid, dnr, len, pl);
            if (b2b) check("b2b_en_before_accept", pre_en, 1);
            check("en_at_accept_edge", tag_en_o, 0);
            @(posedge clk); #1;
            check("start_bit_t_plus_1", {tag_en_o, tag_data_o}, 2'b11);
        end
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy_o) && c < 3000) begin
            @(posedge clk); #1;
            c++;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_busy", busy_o, 0);
    endtask

    always @(negedge clk) begin
        if (tag_en_o) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_bit: got data=%0b with en=1, expected no frame (t=%0t)",
                         tag_data_o, $time);
            end else begin
                exp_bit = exp_q.pop_front();
                check("serial_bit", tag_data_o, exp_bit);
            end
        end else begin
            check("idle_data_zero", tag_data_o, 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by t=%0t, expected a finished run", $time);
        $fatal(1);
    end

    initial begin
        logic [20:0] hand;
        reset_i = 1'b1; v_i = 1'b0; master_reset_v_i = 1'b0;
        node_id_i = '0; data_not_reset_i = 1'b0; len_i = '0; payload_i = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_en", tag_en_o, 0);
        check("rst_data", tag_data_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", ready_o, 0);
        reset_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_en", tag_en_o, 0);
            check("idle_ready", ready_o, 1);
            check("idle_busy", busy_o, 0);
        end

        // node 5, data packet, len 4, payload 4'b1011: hand-derived 21-bit frame
        hand = 21'b1_101000_1_001000000_1101;
        for (int i = 0; i < 21; i++) exp_q.push_back(hand[20-i]);
        send(6'd5, 1'b1, 9'd4, 64'hB, 1'b0, 1'b0, dummy);
        drain();

        // two frames with v_i effectively held: exactly one idle cycle between them
        send(6'd12, 1'b1, 9'd6, 64'h2D, 1'b1, 1'b0, dummy);
        send(6'd40, 1'b0, 9'd3, 64'h5, 1'b1, 1'b1, dummy);
        drain();

        // master reset and data request in the same cycle: preamble wins
        node_id_i = 6'd7; data_not_reset_i = 1'b1; len_i = 9'd5; payload_i = 64'h16;
        v_i = 1'b1; master_reset_v_i = 1'b1;
        @(negedge clk);
        check("mr_priority_ready", ready_o, 0);
        @(posedge clk); #1;
        master_reset_v_i = 1'b0;
        check("mr_busy", busy_o, 1);
        for (int i = 0; i < 1024; i++) exp_q.push_back(1'b1);
        for (int i = 0; i < 16; i++) exp_q.push_back(1'b0);
        send(6'd7, 1'b1, 9'd5, 64'h16, 1'b1, 1'b0, dummy);
        check("mr_ready_low_cycles", dummy, 1040);
        drain();

        // header-only client reset to node 63, then an oversized length
        send(6'd63, 1'b0, 9'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, dummy);
        drain();
        send(6'd17, 1'b1, 9'd70, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, dummy);
        drain();

        // reset in the middle of the payload, then a clean frame
        send(6'd9, 1'b1, 9'd40, 64'hA5A5_5A5A_0F0F_F0F0, 1'b1, 1'b0, dummy);
        repeat (20) @(posedge clk);
        #1;
        reset_i = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        check("midrst_en", tag_en_o, 0);
        check("midrst_data", tag_data_o, 0);
        check("midrst_busy", busy_o, 0);
        reset_i = 1'b0;
        @(posedge clk); #1;
        check("postrst_en", tag_en_o, 0);
        send(6'd33, 1'b1, 9'd8, 64'h3C, 1'b1, 1'b0, dummy);
        drain();

        repeat (5) @(posedge clk);
        #1;
        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
